// File: rtl/mixcol_seq.sv
// Iterative AES MixColumns / InvMixColumns engine. It processes COLS_PER_CYCLE
// columns per step through a shared xtime bank and uses valid/ready handshakes on both sides.
module mixcol_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int         NSTEP    = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_CNT = 2'(NSTEP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state_r, state_s;
  logic [1:0]   col_cnt_r, col_cnt_s;
  logic         inv_r, inv_s;
  logic [127:0] work_r, work_s, mixed_s;
  logic         in_ready_r, out_valid_r, out_valid_s, busy_r;
  logic [127:0] out_state_r, out_state_s;
  logic         pre_sel_s;

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // The four xtime units are muxed: PRE chains them in pairs, MIX uses one per byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic pre);
    logic [7:0] a0, a1, a2, a3, t0, t1, t2, t3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    t0 = xt(pre ? (a0 ^ a2) : a0);
    t1 = xt(pre ? t0 : a1);
    t2 = xt(pre ? (a1 ^ a3) : a2);
    t3 = xt(pre ? t2 : a3);
    if (pre) begin
      mix_col = {a0 ^ t1, a1 ^ t3, a2 ^ t1, a3 ^ t3};
    end else begin
      mix_col = {t0 ^ t1 ^ a1 ^ a2 ^ a3,
                 a0 ^ t1 ^ t2 ^ a2 ^ a3,
                 a0 ^ a1 ^ t2 ^ t3 ^ a3,
                 t0 ^ a0 ^ a1 ^ a2 ^ t3};
    end
  endfunction

  assign pre_sel_s = (state_r == PRE) && inv_r;

  // Column datapath: transform the columns picked by col_cnt, pass the rest through.
  always_comb begin
    mixed_s = work_r;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      mixed_s[127 - 32*(int'(col_cnt_r)*COLS_PER_CYCLE + k) -: 32] =
        mix_col(work_r[127 - 32*(int'(col_cnt_r)*COLS_PER_CYCLE + k) -: 32], pre_sel_s);
    end
  end

  // Next-state logic and working-register updates.
  always_comb begin
    state_s     = state_r;
    col_cnt_s   = col_cnt_r;
    inv_s       = inv_r;
    work_s      = work_r;
    out_valid_s = out_valid_r;
    out_state_s = out_state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          work_s    = in_state;
          inv_s     = in_inv;
          col_cnt_s = 2'd0;
          state_s   = in_inv ? PRE : MIX;
        end else begin
          state_s = IDLE;
        end
      end
      PRE: begin
        work_s = mixed_s;
        if (col_cnt_r == LAST_CNT) begin
          col_cnt_s = 2'd0;
          state_s   = MIX;
        end else begin
          col_cnt_s = col_cnt_r + 2'd1;
        end
      end
      MIX: begin
        work_s = mixed_s;
        if (col_cnt_r == LAST_CNT) begin
          col_cnt_s = 2'd0;
          state_s   = DONE;
        end else begin
          col_cnt_s = col_cnt_r + 2'd1;
        end
      end
      DONE: begin
        // The result is published one cycle after DONE is entered and is held until consumed.
        if (out_valid_r && out_ready) begin
          out_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          out_valid_s = 1'b1;
          out_state_s = work_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      col_cnt_r   <= 2'd0;
      inv_r       <= 1'b0;
      work_r      <= 128'h0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_state_r <= 128'h0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      col_cnt_r   <= col_cnt_s;
      inv_r       <= inv_s;
      work_r      <= work_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= out_valid_s;
      out_state_r <= out_state_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_state = out_state_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mixcol_seq.sv
// Bench for mixcol_seq: three instances (C = 1, 2, 4) are checked against a GF(2^8)
// matrix model, plus directed latency, backpressure and reset vectors.
module tb_mixcol_seq;

  localparam logic [127:0] V1  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1M = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid [3];
  logic         in_ready [3];
  logic         in_inv [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy [3];
  logic [127:0] in_state [3];
  logic [127:0] out_state [3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic         pending [3];
  logic         seen [3];
  logic [127:0] exp_state [3];
  int           exp_lat [3];
  int           acc_cyc [3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mixcol_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .in_inv    (in_inv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  // Field multiply: carry-less product, then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   row0 [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) begin
      row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
    end else begin
      row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
    end
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(row0[(k - rr + 4) % 4], s[127 - 32*c - 8*k -: 8]);
        r[127 - 32*c - 8*rr -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic int lat(input int d, input logic inv);
    return (inv ? 8 : 4) / (1 << d) + 1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every cycle a result is shown it must match the model; first showing checks latency.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        pending[d] <= 1'b0;
        seen[d]    <= 1'b0;
      end else begin
        if (out_valid[d]) begin
          chk1("valid_has_pending", pending[d], 1'b1);
          chk("out_state_vs_model", out_state[d], exp_state[d]);
          if (!seen[d]) chk("latency", 128'(cyc - acc_cyc[d]), 128'(exp_lat[d]));
          seen[d] <= 1'b1;
          if (out_ready[d]) begin
            pending[d] <= 1'b0;
            seen[d]    <= 1'b0;
          end
        end
        if (in_valid[d] && in_ready[d]) begin
          pending[d]   <= 1'b1;
          seen[d]      <= 1'b0;
          exp_state[d] <= model(in_state[d], in_inv[d]);
          exp_lat[d]   <= lat(d, in_inv[d]);
          acc_cyc[d]   <= cyc + 1;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int d, input logic [127:0] s, input logic inv);
    int g = 0;
    in_state[d] = s;
    in_inv[d]   = inv;
    in_valid[d] = 1'b1;
    while (!in_ready[d] && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk1("accept_timeout", in_ready[d], 1'b1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, output logic [127:0] r);
    int g = 0;
    while (!out_valid[d] && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk1("wait_out_timeout", out_valid[d], 1'b1);
    r = out_state[d];
  endtask

  task automatic op_check(input int d, input logic [127:0] s, input logic inv,
                          input logic [127:0] want);
    int L;
    L = lat(d, inv);
    out_ready[d] = 1'b1;
    send(d, s, inv);
    for (int k = 0; k < L; k++) begin
      chk1("busy_during_op", busy[d], 1'b1);
      chk1("no_early_valid", out_valid[d], 1'b0);
      @(posedge clk); #1;
    end
    chk1("valid_at_latency", out_valid[d], 1'b1);
    chk("directed_result", out_state[d], want);
    @(posedge clk); #1;
    chk1("valid_drops", out_valid[d], 1'b0);
    chk1("ready_back", in_ready[d], 1'b1);
    chk1("busy_drops", busy[d], 1'b0);
  endtask

  task automatic rand_run(input int d, input int nops);
    int   sent = 0;
    int   got = 0;
    int   guard = 0;
    logic acc, hs;
    in_state[d] = {$urandom, $urandom, $urandom, $urandom};
    in_inv[d]   = 1'($urandom_range(0, 1));
    while (got < nops && guard < nops * 30) begin
      in_valid[d]  = (sent < nops);
      out_ready[d] = 1'($urandom_range(0, 1));
      acc = in_valid[d] && in_ready[d];
      hs  = out_valid[d] && out_ready[d];
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        in_state[d] = {$urandom, $urandom, $urandom, $urandom};
        in_inv[d]   = 1'($urandom_range(0, 1));
      end
      if (hs) got++;
      guard++;
    end
    chk1("random_drain", (got == nops), 1'b1);
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
  endtask

  initial begin
    logic [127:0] x, y, z;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_inv[d]    = 1'b0;
      in_state[d]  = 128'h0;
      out_ready[d] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk1("reset_in_ready", in_ready[d], 1'b1);
      chk1("reset_out_valid", out_valid[d], 1'b0);
      chk1("reset_busy", busy[d], 1'b0);
      chk("reset_out_state", out_state[d], 128'h0);
    end
    rst = 1'b0;

    chk("gmul_pin", 128'(gmul(8'h57, 8'h83)), 128'hc1);
    chk("model_fwd_pin", model(V1, 1'b0), V1M);
    chk("model_inv_pin", model(V1M, 1'b1), V1);

    for (int d = 0; d < 3; d++) begin
      op_check(d, V1, 1'b0, V1M);
      op_check(d, V1M, 1'b1, V1);
    end

    // Backpressure with an ignored input offered during the stall.
    out_ready[0] = 1'b0;
    send(0, V1, 1'b0);
    wait_out(0, x);
    chk("stall_first", x, V1M);
    in_state[0] = V1M;
    in_inv[0]   = 1'b1;
    in_valid[0] = 1'b1;
    repeat (7) begin
      @(posedge clk); #1;
      chk1("stall_valid", out_valid[0], 1'b1);
      chk("stall_state", out_state[0], V1M);
      chk1("stall_in_ready", in_ready[0], 1'b0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk1("stall_release_valid", out_valid[0], 1'b0);
    chk1("stall_release_ready", in_ready[0], 1'b1);
    repeat (6) begin
      @(posedge clk); #1;
      chk1("ignored_input_absent", out_valid[0], 1'b0);
    end

    // Reset during the third MIX cycle.
    send(0, V1, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("midrst_in_ready", in_ready[0], 1'b1);
    chk1("midrst_out_valid", out_valid[0], 1'b0);
    chk("midrst_out_state", out_state[0], 128'h0);
    op_check(0, V1, 1'b0, V1M);

    fork
      rand_run(0, 1000);
      rand_run(1, 1000);
      rand_run(2, 1000);
    join
    repeat (2) @(posedge clk);
    #1;

    for (int d = 0; d < 3; d++) begin
      repeat (3) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        send(d, x, 1'b0);
        wait_out(d, y);
        send(d, y, 1'b1);
        wait_out(d, z);
        chk("roundtrip", z, x);
      end
    end
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
